morse_decoder: RTL and testbench

// - Downstream receiver for the Lab 5 Morse transmitter: samples the serial DotDashOut line once per Morse unit,

---
 rtl/morse_pkg.sv | 78 +++++++
 rtl/morse_decoder_if.sv | 20 ++
 rtl/morse_tick_gen.sv | 34 +++
 rtl/morse_decoder.sv | 162 ++++++++++++++++
 tb/tb_morse_decoder.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse receiver: letter codes, symbol encoding,
// run-length thresholds, the FSM state type and the (count, pattern) decode
// table with its lookup function.
// No ports.
// -----------------------------------------------------------------------------
package morse_pkg;

   // Letter codes A..H
   localparam logic [2:0] LTR_A = 3'b000;
   localparam logic [2:0] LTR_B = 3'b001;
   localparam logic [2:0] LTR_C = 3'b010;
   localparam logic [2:0] LTR_D = 3'b011;
   localparam logic [2:0] LTR_E = 3'b100;
   localparam logic [2:0] LTR_F = 3'b101;
   localparam logic [2:0] LTR_G = 3'b110;
   localparam logic [2:0] LTR_H = 3'b111;

   // Symbol encoding in the shift buffer
   localparam logic SYM_DOT  = 1'b0;
   localparam logic SYM_DASH = 1'b1;

   // Run-length thresholds, in Morse units
   localparam logic [2:0] MAX_SYM     = 3'd4;  // symbols per letter
   localparam logic [2:0] RUN_MAX     = 3'd7;  // run counter saturation
   localparam logic [2:0] DASH_MIN    = 3'd2;  // mark of 2..3 units is a dash
   localparam logic [2:0] ILLEGAL_RUN = 3'd4;  // mark of 4+ units is illegal
   localparam logic [2:0] GAP_UNITS   = 3'd3;  // space that ends a letter

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_MARK   = 3'd1,
      ST_SPACE  = 3'd2,
      ST_DECODE = 3'd3,
      ST_ERR    = 3'd4,
      ST_DRAIN  = 3'd5
   } state_t;

   typedef struct packed {
      logic [2:0] count;
      logic [3:0] pattern;  // oldest symbol in the highest used bit
   } code_t;

   typedef struct packed {
      logic       hit;
      logic [2:0] letter;
   } lookup_t;

   // Indexed by letter code, so entry i decodes to letter i.
   localparam code_t CODE_TABLE [8] = '{
      '{3'd2, 4'b0001},   // A .-
      '{3'd4, 4'b1000},   // B -...
      '{3'd4, 4'b1010},   // C -.-.
      '{3'd3, 4'b0100},   // D -..
      '{3'd1, 4'b0000},   // E .
      '{3'd4, 4'b0010},   // F ..-.
      '{3'd3, 4'b0110},   // G --.
      '{3'd4, 4'b0000}    // H ....
   };

   // Unused upper buffer bits are always zero (buffer cleared per letter),
   // so the full 4-bit pattern can be compared directly.
   function automatic lookup_t lookup_letter(input logic [2:0] count,
                                             input logic [3:0] pattern);
      lookup_t res;
      logic    match;
      res   = '{hit: 1'b0, letter: 3'b000};
      match = 1'b0;
      for (int i = 0; i < 8; i++) begin
         match      = (CODE_TABLE[i].count == count) && (CODE_TABLE[i].pattern == pattern);
         res.letter = match ? 3'(i) : res.letter;
         res.hit    = res.hit | match;
      end
      return res;
   endfunction

endpackage

// File: rtl/morse_decoder_if.sv
// -----------------------------------------------------------------------------
// morse_decoder_if
// Groups the serial Morse input with the decoded-letter outputs.
//   DotDashIn   serial line (1 = key down)
//   LetterOut   decoded letter code
//   LetterValid one-cycle strobe, LetterOut updated
//   ErrorPulse  one-cycle strobe, letter discarded
//   Busy        letter being assembled
// Modports: slave = decoder side, master = line driver / letter consumer.
// -----------------------------------------------------------------------------
interface morse_decoder_if;
   logic       DotDashIn;
   logic [2:0] LetterOut;
   logic       LetterValid;
   logic       ErrorPulse;
   logic       Busy;

   modport master (output DotDashIn, input LetterOut, LetterValid, ErrorPulse, Busy);
   modport slave  (input DotDashIn, output LetterOut, LetterValid, ErrorPulse, Busy);
endinterface

// File: rtl/morse_tick_gen.sv
// -----------------------------------------------------------------------------
// morse_tick_gen
// Free-running divider 0..TICK_DIV-1 with a one-cycle strobe when the count
// equals SAMPLE_PHASE. Use SAMPLE_PHASE=TICK_DIV-1 for an end-of-unit tick.
//   ClockIn  in  system clock
//   Resetn   in  synchronous active-low reset (divider to 0)
//   sample   out strobe, high while count == SAMPLE_PHASE
// -----------------------------------------------------------------------------
module morse_tick_gen #(
   parameter int unsigned TICK_DIV     = 250,
   parameter int unsigned SAMPLE_PHASE = 125
) (
   input  logic ClockIn,
   input  logic Resetn,
   output logic sample
);
   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] count_r;

   // Divider counter, wraps at TICK_DIV-1 regardless of decoder state
   always_ff @(posedge ClockIn) begin
      if (!Resetn) begin
         count_r <= '0;
      end else if (count_r == CW'(TICK_DIV - 1)) begin
         count_r <= '0;
      end else begin
         count_r <= count_r + CW'(1'b1);
      end
   end

   assign sample = (count_r == CW'(SAMPLE_PHASE));

endmodule

// File: rtl/morse_decoder.sv
// -----------------------------------------------------------------------------
// morse_decoder
// Samples the serial Morse line once per unit, measures mark/space run lengths,
// assembles dot/dash symbols and decodes letters A..H.
//   ClockIn  in  system clock
//   Resetn   in  synchronous active-low reset
//   bus      slave modport of morse_decoder_if (DotDashIn in; LetterOut,
//            LetterValid, ErrorPulse, Busy out, all registered)
// -----------------------------------------------------------------------------
module morse_decoder
   import morse_pkg::*;
#(
   parameter int unsigned TICK_DIV     = 250,
   parameter int unsigned SAMPLE_PHASE = 125
) (
   input  logic           ClockIn,
   input  logic           Resetn,
   morse_decoder_if.slave bus
);

   state_t     state_r,  state_s;
   logic [2:0] run_r,    run_s;
   logic       level_r;
   logic [3:0] shift_r,  shift_s;
   logic [2:0] count_r,  count_s;
   logic [2:0] letter_r, letter_s;
   logic       valid_r,  valid_s;
   logic       error_r,  error_s;
   logic       busy_r;

   logic       sample_s;
   logic       line_s;
   logic       sym_s;
   logic       illegal_s;
   logic       full_s;
   lookup_t    lookup_s;

   morse_tick_gen #(
      .TICK_DIV     (TICK_DIV),
      .SAMPLE_PHASE (SAMPLE_PHASE)
   ) u_tick (
      .ClockIn (ClockIn),
      .Resetn  (Resetn),
      .sample  (sample_s)
   );

   assign line_s    = bus.DotDashIn;
   // Classification uses the length of the mark that is just ending (run_r).
   assign sym_s     = (run_r >= DASH_MIN) ? SYM_DASH : SYM_DOT;
   assign illegal_s = (run_r >= ILLEGAL_RUN);
   assign full_s    = (count_r >= MAX_SYM);
   assign lookup_s  = lookup_letter(count_r, shift_r);

   // Run length of the current sampled level; restarts at 1 on a level change
   always_comb begin
      run_s = run_r;
      if (sample_s) begin
         if (line_s == level_r) begin
            run_s = (run_r == RUN_MAX) ? RUN_MAX : run_r + 3'd1;
         end else begin
            run_s = 3'd1;
         end
      end else begin
         run_s = run_r;
      end
   end

   // Next-state and output logic; strobes are computed on entry to DECODE/ERR
   // so that, once registered, they coincide with that one-cycle state.
   always_comb begin
      state_s  = state_r;
      shift_s  = shift_r;
      count_s  = count_r;
      letter_s = letter_r;
      valid_s  = 1'b0;
      error_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (sample_s && line_s) begin
               state_s = ST_MARK;
               shift_s = 4'b0000;
               count_s = 3'd0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_MARK: begin
            if (sample_s && !line_s) begin
               if (illegal_s || full_s) begin
                  state_s = ST_ERR;
                  error_s = 1'b1;
               end else begin
                  state_s = ST_SPACE;
                  shift_s = {shift_r[2:0], sym_s};
                  count_s = count_r + 3'd1;
               end
            end else begin
               state_s = ST_MARK;
            end
         end
         ST_SPACE: begin
            if (sample_s && line_s) begin
               state_s = ST_MARK;
            end else if (sample_s && (run_s >= GAP_UNITS)) begin
               state_s  = ST_DECODE;
               valid_s  = lookup_s.hit;
               error_s  = !lookup_s.hit;
               letter_s = lookup_s.hit ? lookup_s.letter : letter_r;
            end else begin
               state_s = ST_SPACE;
            end
         end
         ST_DECODE: begin
            state_s = ST_IDLE;
         end
         ST_ERR: begin
            state_s = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (sample_s && !line_s && (run_s >= GAP_UNITS)) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, datapath and registered outputs; reset wins over the sample strobe
   always_ff @(posedge ClockIn) begin
      if (!Resetn) begin
         state_r  <= ST_IDLE;
         run_r    <= 3'd0;
         level_r  <= 1'b0;
         shift_r  <= 4'b0000;
         count_r  <= 3'd0;
         letter_r <= 3'b000;
         valid_r  <= 1'b0;
         error_r  <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         run_r    <= run_s;
         level_r  <= sample_s ? line_s : level_r;
         shift_r  <= shift_s;
         count_r  <= count_s;
         letter_r <= letter_s;
         valid_r  <= valid_s;
         error_r  <= error_s;
         busy_r   <= (state_s != ST_IDLE);
      end
   end

   assign bus.LetterOut   = letter_r;
   assign bus.LetterValid = valid_r;
   assign bus.ErrorPulse  = error_r;
   assign bus.Busy        = busy_r;

endmodule

// File: tb/tb_morse_decoder.sv
// -----------------------------------------------------------------------------
// tb_morse_decoder
// Directed bench for morse_decoder with TICK_DIV=4, SAMPLE_PHASE=2. One line
// unit = 4 clocks, aligned to the divider after every reset.
// -----------------------------------------------------------------------------
module tb_morse_decoder;
   logic ClockIn = 1'b0;
   logic Resetn  = 1'b0;

   int errors    = 0;
   int checks    = 0;
   int valid_cnt = 0;
   int err_cnt   = 0;
   int both_cnt  = 0;
   logic [2:0] letters [0:63];

   morse_decoder_if bus ();

   morse_decoder #(
      .TICK_DIV     (4),
      .SAMPLE_PHASE (2)
   ) dut (
      .ClockIn (ClockIn),
      .Resetn  (Resetn),
      .bus     (bus)
   );

   always #5 ClockIn = ~ClockIn;

   // Strobe monitor on the falling edge
   always @(negedge ClockIn) begin
      if (bus.LetterValid === 1'b1) begin
         letters[valid_cnt % 64] <= bus.LetterOut;
         valid_cnt <= valid_cnt + 1;
      end
      if (bus.ErrorPulse === 1'b1) err_cnt <= err_cnt + 1;
      if (bus.LetterValid === 1'b1 && bus.ErrorPulse === 1'b1) both_cnt <= both_cnt + 1;
   end

   task automatic drive_unit(input logic b);
      bus.DotDashIn = b;
      repeat (4) @(posedge ClockIn);
      #1;
   endtask

   task automatic send_symbols(input string pat);
      for (int i = 0; i < pat.len(); i++) begin
         if (i != 0) drive_unit(1'b0);
         if (pat[i] == "-") begin
            drive_unit(1'b1); drive_unit(1'b1); drive_unit(1'b1);
         end else begin
            drive_unit(1'b1);
         end
      end
   endtask

   task automatic send_gap();
      repeat (3) drive_unit(1'b0);
   endtask

   task automatic test_reset();
      Resetn = 1'b0;
      bus.DotDashIn = 1'b0;
      repeat (3) @(posedge ClockIn);
      #1;
      checks++; if (bus.LetterOut !== 3'b000) begin errors++; $display("FAIL reset_letter: got %b want 000", bus.LetterOut); end
      checks++; if (bus.LetterValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.LetterValid); end
      checks++; if (bus.ErrorPulse !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", bus.ErrorPulse); end
      checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
      Resetn = 1'b1;
   endtask

   task automatic test_letter_a();
      int v0, e0;
      v0 = valid_cnt; e0 = err_cnt;
      drive_unit(1'b1);
      checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL a_busy_mid: got %b want 1", bus.Busy); end
      drive_unit(1'b0); drive_unit(1'b1); drive_unit(1'b1); drive_unit(1'b1);
      drive_unit(1'b0); drive_unit(1'b0);
      // third space unit: strobe expected right after its sample edge
      bus.DotDashIn = 1'b0;
      repeat (3) @(posedge ClockIn);
      #1;
      checks++; if (bus.LetterValid !== 1'b1) begin errors++; $display("FAIL a_latency_valid: got %b want 1", bus.LetterValid); end
      checks++; if (bus.LetterOut !== 3'b000) begin errors++; $display("FAIL a_letter: got %b want 000", bus.LetterOut); end
      checks++; if (bus.ErrorPulse !== 1'b0) begin errors++; $display("FAIL a_error: got %b want 0", bus.ErrorPulse); end
      @(posedge ClockIn);
      #1;
      checks++; if (bus.LetterValid !== 1'b0) begin errors++; $display("FAIL a_valid_one_cycle: got %b want 0", bus.LetterValid); end
      checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL a_busy_after: got %b want 0", bus.Busy); end
      checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL a_strobe_count: got %0d want 1", valid_cnt - v0); end
      checks++; if (err_cnt - e0 != 0) begin errors++; $display("FAIL a_error_count: got %0d want 0", err_cnt - e0); end
   endtask

   task automatic test_letters_b_to_h();
      string pats [7] = '{"-...", "-.-.", "-..", ".", "..-.", "--.", "...."};
      logic [2:0] exp_l [7] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
      int v0, e0;
      v0 = valid_cnt; e0 = err_cnt;
      for (int i = 0; i < 7; i++) begin
         send_symbols(pats[i]);
         send_gap();
      end
      checks++; if (valid_cnt - v0 != 7) begin errors++; $display("FAIL bh_strobe_count: got %0d want 7", valid_cnt - v0); end
      checks++; if (err_cnt - e0 != 0) begin errors++; $display("FAIL bh_error_count: got %0d want 0", err_cnt - e0); end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (letters[(v0 + i) % 64] !== exp_l[i]) begin
            errors++; $display("FAIL bh_letter_%0d: got %b want %b", i, letters[(v0 + i) % 64], exp_l[i]);
         end
      end
   endtask

   task automatic test_long_mark();
      int v0, e0;
      v0 = valid_cnt; e0 = err_cnt;
      repeat (4) drive_unit(1'b1);
      drive_unit(1'b0);
      checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL long_error_count: got %0d want 1", err_cnt - e0); end
      drive_unit(1'b0);
      checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL long_busy_drain: got %b want 1", bus.Busy); end
      drive_unit(1'b0);
      checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL long_busy_idle: got %b want 0", bus.Busy); end
      send_symbols(".");
      send_gap();
      checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL long_strobe_count: got %0d want 1", valid_cnt - v0); end
      checks++; if (bus.LetterOut !== 3'b100) begin errors++; $display("FAIL long_then_e: got %b want 100", bus.LetterOut); end
      checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL long_error_total: got %0d want 1", err_cnt - e0); end
   endtask

   task automatic test_saturation();
      int v0, e0;
      v0 = valid_cnt; e0 = err_cnt;
      repeat (9) drive_unit(1'b1);
      send_gap();
      checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL sat_error_count: got %0d want 1", err_cnt - e0); end
      checks++; if (valid_cnt - v0 != 0) begin errors++; $display("FAIL sat_strobe_count: got %0d want 0", valid_cnt - v0); end
      checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL sat_busy: got %b want 0", bus.Busy); end
   endtask

   task automatic test_back_to_back();
      logic [11:0] c_frame;
      int v0, e0;
      c_frame = 12'b111010111010;
      v0 = valid_cnt; e0 = err_cnt;
      for (int i = 11; i >= 0; i--) drive_unit(c_frame[i]);
      for (int i = 11; i >= 9; i--) drive_unit(c_frame[i]);
      checks++; if (err_cnt - e0 != 0) begin errors++; $display("FAIL b2b_early_error: got %0d want 0", err_cnt - e0); end
      drive_unit(c_frame[8]);
      checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL b2b_fifth_symbol: got %0d want 1", err_cnt - e0); end
      for (int i = 7; i >= 0; i--) drive_unit(c_frame[i]);
      checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_drain: got %b want 1", bus.Busy); end
      send_gap();
      checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_idle: got %b want 0", bus.Busy); end
      checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL b2b_error_total: got %0d want 1", err_cnt - e0); end
      checks++; if (valid_cnt - v0 != 0) begin errors++; $display("FAIL b2b_strobe_count: got %0d want 0", valid_cnt - v0); end
      checks++; if (bus.LetterOut !== 3'b100) begin errors++; $display("FAIL b2b_letter_hold: got %b want 100", bus.LetterOut); end
   endtask

   task automatic test_reset_mid_letter();
      int v0, e0;
      v0 = valid_cnt; e0 = err_cnt;
      send_symbols("--");
      checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL rst_busy_before: got %b want 1", bus.Busy); end
      bus.DotDashIn = 1'b0;
      Resetn = 1'b0;
      @(posedge ClockIn);
      #1;
      Resetn = 1'b1;
      checks++; if (bus.LetterOut !== 3'b000) begin errors++; $display("FAIL rst_letter: got %b want 000", bus.LetterOut); end
      checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.Busy); end
      repeat (4) drive_unit(1'b0);
      checks++; if (valid_cnt - v0 != 0) begin errors++; $display("FAIL rst_no_strobe: got %0d want 0", valid_cnt - v0); end
      checks++; if (err_cnt - e0 != 0) begin errors++; $display("FAIL rst_no_error: got %0d want 0", err_cnt - e0); end
      send_symbols("....");
      send_gap();
      checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL rst_h_count: got %0d want 1", valid_cnt - v0); end
      checks++; if (bus.LetterOut !== 3'b111) begin errors++; $display("FAIL rst_h_letter: got %b want 111", bus.LetterOut); end
   endtask

   task automatic test_bad_patterns();
      int v0, e0;
      v0 = valid_cnt; e0 = err_cnt;
      send_symbols("..-..");
      send_gap();
      checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL five_sym_error: got %0d want 1", err_cnt - e0); end
      checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL five_sym_busy: got %b want 0", bus.Busy); end
      send_symbols("--");
      send_gap();
      checks++; if (err_cnt - e0 != 2) begin errors++; $display("FAIL miss_error: got %0d want 2", err_cnt - e0); end
      checks++; if (valid_cnt - v0 != 0) begin errors++; $display("FAIL bad_strobe_count: got %0d want 0", valid_cnt - v0); end
      checks++; if (bus.LetterOut !== 3'b111) begin errors++; $display("FAIL miss_letter_hold: got %b want 111", bus.LetterOut); end
      checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL miss_busy: got %b want 0", bus.Busy); end
      checks++; if (both_cnt != 0) begin errors++; $display("FAIL strobe_overlap: got %0d want 0", both_cnt); end
   endtask

   initial begin
      bus.DotDashIn = 1'b0;
      test_reset();
      test_letter_a();
      test_letters_b_to_h();
      test_long_mark();
      test_saturation();
      test_back_to_back();
      test_reset_mid_letter();
      test_bad_patterns();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
